// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit
// ----------------------------------------------------------------------------
// Memory-stage data-memory access unit. Takes the EX/MEM register outputs and
// runs one handshaked bus transaction per aligned load or store. Store data is
// lane-replicated with byte strobes; load data is lane-selected and then sign-
// or zero-extended before being handed to the MEM/WB register. The pipeline is
// frozen (Stall_M) while a transaction is outstanding, and a transaction that
// gets no response within TIMEOUT_CYCLES cycles of REQ+RESP is aborted with
// Bus_Err_M.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   MEM_R_En_M          load in M stage
//   MEM_W_En_M          store in M stage (wins if both enables are set)
//   MEM_Control_M[2:0]  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALU_Out_M[31:0]     effective byte address
//   SrcB_Reg_M[31:0]    store data
//   Hold_M              downstream hold, keeps the unit in DONE
//   DMEM_*              request/grant/response data-memory bus
//   Read_Data_M[31:0]   extended load result
//   Stall_M             freeze the upstream pipeline registers
//   Misaligned_M        combinational misalignment flag
//   Bus_Err_M           timeout abort flag, valid in DONE
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_R_En_M,
    input  logic        MEM_W_En_M,
    input  logic [2:0]  MEM_Control_M,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] SrcB_Reg_M,
    input  logic        Hold_M,
    output logic        DMEM_Req,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_Addr,
    output logic [31:0] DMEM_WData,
    output logic [3:0]  DMEM_BE,
    input  logic        DMEM_Gnt,
    input  logic        DMEM_RValid,
    input  logic [31:0] DMEM_RData,
    output logic [31:0] Read_Data_M,
    output logic        Stall_M,
    output logic        Misaligned_M,
    output logic        Bus_Err_M
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             access;
    logic             isHalf;
    logic             isWord;
    logic             misaligned;
    logic             completion;
    logic [3:0]       stBe;
    logic [31:0]      stWData;
    logic [7:0]       ldByte;
    logic [15:0]      ldHalf;
    logic [31:0]      ldData;

    // Access qualification and misalignment. Bytes can never be misaligned.
    assign access     = MEM_R_En_M | MEM_W_En_M;
    assign isHalf     = (MEM_Control_M[1:0] == 2'b01);
    assign isWord     = (MEM_Control_M[1:0] == 2'b10);
    assign misaligned = access & ((isHalf & ALU_Out_M[0]) |
                                  (isWord & (ALU_Out_M[1:0] != 2'b00)));

    // The instruction is frozen in EX/MEM while we stall, so the live control
    // and address inputs are still valid when the response arrives.
    assign completion = DMEM_RValid &
                        ((state_q == RESP) | ((state_q == REQ) & DMEM_Gnt));

    // Store lane mapping: replicate the significant bytes across the word and
    // strobe only the lanes the access actually touches.
    always_comb begin
        stBe    = 4'b1111;
        stWData = SrcB_Reg_M;
        case (MEM_Control_M[1:0])
            2'b00: begin
                stBe    = 4'b0001 << ALU_Out_M[1:0];
                stWData = {4{SrcB_Reg_M[7:0]}};
            end
            2'b01: begin
                stBe    = 4'b0011 << ALU_Out_M[1:0];
                stWData = {2{SrcB_Reg_M[15:0]}};
            end
            default: begin
                stBe    = 4'b1111;
                stWData = SrcB_Reg_M;
            end
        endcase
    end

    // Load extraction: pick the addressed lane, then extend. funct3[2] set
    // selects the unsigned (zero-extending) variants.
    always_comb begin
        ldByte = DMEM_RData[{ALU_Out_M[1:0], 3'b000} +: 8];
        ldHalf = DMEM_RData[{ALU_Out_M[1], 4'b0000} +: 16];
        case (MEM_Control_M[1:0])
            2'b00:   ldData = {{24{~MEM_Control_M[2] & ldByte[7]}}, ldByte};
            2'b01:   ldData = {{16{~MEM_Control_M[2] & ldHalf[15]}}, ldHalf};
            default: ldData = DMEM_RData;
        endcase
    end

    // Next-state logic. A response always wins over the timeout in the last
    // allowed cycle; the counter only advances when nothing completes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = MEM_W_En_M;
                    addr_d  = {ALU_Out_M[31:2], 2'b00};
                    wdata_d = stWData;
                    be_d    = stBe;
                end
            end
            REQ, RESP: begin
                if (completion) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = ldData;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((state_q == REQ) && DMEM_Gnt) begin
                        req_d   = 1'b0;
                        state_d = RESP;
                    end
                end
            end
            DONE: begin
                if (!Hold_M) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered bus outputs. Reset abandons any transaction in
    // flight; a late grant or response then lands in IDLE and is ignored.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign DMEM_Req     = req_q;
    assign DMEM_WE      = we_q;
    assign DMEM_Addr    = addr_q;
    assign DMEM_WData   = wdata_q;
    assign DMEM_BE      = be_q;
    assign Read_Data_M  = rdata_q;
    assign Bus_Err_M    = err_q;
    assign Misaligned_M = misaligned;
    assign Stall_M      = access & ~misaligned & (state_q != DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit
// ----------------------------------------------------------------------------
// Scoreboard bench for mem_access_unit. The stimulus process issues loads and
// stores, plays the memory slave, and pushes the expected bus request and the
// expected MEM/WB result into queues. A monitor on the falling edge pops and
// compares whenever the DUT raises a request or enters its DONE window.
// Expected values come from a byte/size level memory model, not from the
// DUT's own state machine.
// ============================================================================
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        MEM_R_En_M, MEM_W_En_M, Hold_M;
    logic [2:0]  MEM_Control_M;
    logic [31:0] ALU_Out_M, SrcB_Reg_M;
    logic        DMEM_Req, DMEM_WE, DMEM_Gnt, DMEM_RValid;
    logic [31:0] DMEM_Addr, DMEM_WData, DMEM_RData;
    logic [3:0]  DMEM_BE;
    logic [31:0] Read_Data_M;
    logic        Stall_M, Misaligned_M, Bus_Err_M;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } busExp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resExp_t;

    busExp_t     busQ[$];
    resExp_t     resQ[$];
    logic [31:0] lastRead = 32'h0;

    mem_access_unit #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W         (5)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .MEM_R_En_M   (MEM_R_En_M),
        .MEM_W_En_M   (MEM_W_En_M),
        .MEM_Control_M(MEM_Control_M),
        .ALU_Out_M    (ALU_Out_M),
        .SrcB_Reg_M   (SrcB_Reg_M),
        .Hold_M       (Hold_M),
        .DMEM_Req     (DMEM_Req),
        .DMEM_WE      (DMEM_WE),
        .DMEM_Addr    (DMEM_Addr),
        .DMEM_WData   (DMEM_WData),
        .DMEM_BE      (DMEM_BE),
        .DMEM_Gnt     (DMEM_Gnt),
        .DMEM_RValid  (DMEM_RValid),
        .DMEM_RData   (DMEM_RData),
        .Read_Data_M  (Read_Data_M),
        .Stall_M      (Stall_M),
        .Misaligned_M (Misaligned_M),
        .Bus_Err_M    (Bus_Err_M)
    );

    // Free-running 10-unit clock.
    always #5 CLK = ~CLK;

    // Single comparison point: every check counts, every miss prints FAIL.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Event that should never happen (e.g. DUT output with nothing expected).
    task automatic reportUnexpected(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: DUT produced an output with an empty scoreboard", name);
    endtask

    // Access size in bytes from funct3.
    function automatic int sizeOf(input logic [2:0] ctrl);
        case (ctrl)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Expected bus request: the word containing the address, strobes covering
    // 'size' bytes starting at the byte offset, data bytes repeated per lane.
    function automatic busExp_t busModel(input logic we, input logic [2:0] ctrl,
                                         input logic [31:0] addr, input logic [31:0] data);
        busExp_t e;
        int size;
        int off;
        size    = sizeOf(ctrl);
        off     = int'(addr[1:0]);
        e.we    = we;
        e.addr  = addr & ~32'h3;
        e.be    = 4'(((1 << size) - 1) << off);
        e.wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            e.wdata[i*8 +: 8] = data[(i % size)*8 +: 8];
        end
        return e;
    endfunction

    // Expected load result: shift the addressed bytes down, mask to size,
    // then extend with the top bit unless the unsigned variant is used.
    function automatic logic [31:0] loadModel(input logic [2:0] ctrl, input logic [31:0] addr,
                                              input logic [31:0] word);
        int size;
        logic [31:0] raw;
        logic [31:0] mask;
        size = sizeOf(ctrl);
        if (size == 4) return word;
        raw  = word >> (int'(addr[1:0]) * 8);
        mask = (32'h1 << (size * 8)) - 32'h1;
        raw  = raw & mask;
        if (!ctrl[2] && raw[size*8-1]) raw = raw | ~mask;
        return raw;
    endfunction

    // Issue one instruction, act as the memory slave with the given grant and
    // response delays, and hold DONE for 'hold' extra cycles.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] ctrl,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] rdata, input int gntDelay,
                                 input int rvDelay, input int hold);
        busExp_t be;
        resExp_t re;
        int size, gntCyc, rvCyc, expStalls, stalls;
        logic mis;
        size          = sizeOf(ctrl);
        mis           = (addr % 32'(size)) != 32'h0;
        MEM_R_En_M    = rd;
        MEM_W_En_M    = wr;
        MEM_Control_M = ctrl;
        ALU_Out_M     = addr;
        SrcB_Reg_M    = data;
        DMEM_RData    = rdata;
        Hold_M        = (hold > 0);
        DMEM_Gnt      = 1'b0;
        DMEM_RValid   = 1'b0;
        #1;
        if (mis) begin
            checkOutput("misaligned_stall", 32'(Stall_M), 32'h0);
            repeat (2) begin
                @(posedge CLK); #1;
                checkOutput("misaligned_no_req", 32'(DMEM_Req), 32'h0);
                checkOutput("misaligned_read_hold", Read_Data_M, lastRead);
            end
        end else begin
            be = busModel(wr, ctrl, addr, data);
            busQ.push_back(be);
            gntCyc = 1 + gntDelay;
            rvCyc  = gntCyc + rvDelay;
            // One issue cycle in IDLE plus the cycles spent in REQ/RESP,
            // which are capped at TIMEOUT.
            if (rvCyc > TIMEOUT) begin
                expStalls = TIMEOUT + 1;
                re.rdata  = 32'h0;
                re.err    = 1'b1;
            end else begin
                expStalls = rvCyc + 1;
                re.rdata  = wr ? lastRead : loadModel(ctrl, addr, rdata);
                re.err    = 1'b0;
            end
            lastRead = re.rdata;
            resQ.push_back(re);
            stalls = 0;
            for (int cyc = 0; cyc < 64; cyc++) begin
                if (!Stall_M) break;
                DMEM_Gnt    = (cyc == gntCyc);
                DMEM_RValid = (cyc == rvCyc);
                stalls++;
                @(posedge CLK); #1;
            end
            DMEM_Gnt    = 1'b0;
            DMEM_RValid = 1'b0;
            checkOutput("stall_cycles", 32'(stalls), 32'(expStalls));
            for (int h = 0; h < hold; h++) begin
                @(posedge CLK); #1;
                checkOutput("hold_keeps_done", 32'(Stall_M), 32'h0);
            end
            Hold_M = 1'b0;
            @(posedge CLK); #1;
            checkOutput("idle_clears_bus_err", 32'(Bus_Err_M), 32'h0);
        end
        MEM_R_En_M = 1'b0;
        MEM_W_En_M = 1'b0;
    endtask

    // Monitor: compares the DUT against the scoreboard on the falling edge.
    logic    reqSeen = 1'b0;
    logic    inDone  = 1'b0;
    logic    monAccess, monMis;
    resExp_t held;
    busExp_t got;

    always @(negedge CLK) begin
        if (RST) begin
            monAccess = MEM_R_En_M | MEM_W_En_M;
            monMis    = monAccess && ((ALU_Out_M % 32'(sizeOf(MEM_Control_M))) != 32'h0);
            checkOutput("misaligned_flag", 32'(Misaligned_M), 32'(monMis));
            if (DMEM_Req && !reqSeen) begin
                if (busQ.size() == 0) begin
                    reportUnexpected("unexpected_request");
                end else begin
                    got = busQ.pop_front();
                    checkOutput("bus_we", 32'(DMEM_WE), 32'(got.we));
                    checkOutput("bus_addr", DMEM_Addr, got.addr);
                    checkOutput("bus_be", 32'(DMEM_BE), 32'(got.be));
                    if (got.we) checkOutput("bus_wdata", DMEM_WData, got.wdata);
                end
            end
            reqSeen = DMEM_Req;
            if (monAccess && !monMis && !Stall_M) begin
                if (!inDone) begin
                    if (resQ.size() == 0) reportUnexpected("unexpected_done");
                    else held = resQ.pop_front();
                end
                checkOutput("read_data", Read_Data_M, held.rdata);
                checkOutput("bus_err", 32'(Bus_Err_M), 32'(held.err));
                inDone = 1'b1;
            end else begin
                inDone = 1'b0;
            end
        end else begin
            reqSeen = 1'b0;
            inDone  = 1'b0;
        end
    end

    // Main stimulus sequence: directed cases first, then randomized traffic.
    initial begin
        logic [2:0]  ctrlTab[5];
        logic [2:0]  ctrl;
        logic [31:0] addr;
        int          op, size, hold;
        ctrlTab[0] = 3'b000; ctrlTab[1] = 3'b001; ctrlTab[2] = 3'b010;
        ctrlTab[3] = 3'b100; ctrlTab[4] = 3'b101;

        MEM_R_En_M = 0; MEM_W_En_M = 0; MEM_Control_M = 0; ALU_Out_M = 0;
        SrcB_Reg_M = 0; Hold_M = 0; DMEM_Gnt = 0; DMEM_RValid = 0; DMEM_RData = 0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_ctrl", 32'({DMEM_Req, DMEM_WE, DMEM_BE, Bus_Err_M, Stall_M}), 32'h0);
        checkOutput("reset_addr", DMEM_Addr, 32'h0);
        checkOutput("reset_wdata", DMEM_WData, 32'h0);
        checkOutput("reset_read_data", Read_Data_M, 32'h0);
        RST = 1'b1;
        @(posedge CLK); #1;

        $display("[TB] directed loads and stores");
        applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0);
        applyStimulus(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 1, 0);
        applyStimulus(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 1, 0);
        applyStimulus(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 0, 1, 0);
        applyStimulus(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0, 1, 0);
        applyStimulus(0, 1, 3'b001, 32'h202, 32'h12345678, 32'h0, 0, 1, 0);
        applyStimulus(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1, 0);
        applyStimulus(1, 0, 3'b001, 32'h106, 32'h0, 32'h0000F00D, 1, 0, 0);

        $display("[TB] grant withheld past the timeout");
        applyStimulus(1, 0, 3'b010, 32'h400, 32'h0, 32'h11111111, 20, 0, 0);

        $display("[TB] hold in DONE");
        applyStimulus(1, 0, 3'b010, 32'h500, 32'h0, 32'hABCD1234, 0, 1, 3);

        $display("[TB] reset while waiting for the response");
        MEM_R_En_M = 1; MEM_W_En_M = 0; MEM_Control_M = 3'b010;
        ALU_Out_M = 32'h300; SrcB_Reg_M = 32'h0; DMEM_RData = 32'h12345678;
        busQ.push_back(busModel(1'b0, 3'b010, 32'h300, 32'h0));
        @(posedge CLK); #1;
        DMEM_Gnt = 1'b1;
        @(posedge CLK); #1;
        DMEM_Gnt = 1'b0;
        checkOutput("resp_stall", 32'(Stall_M), 32'h1);
        #2;
        RST = 1'b0;
        MEM_R_En_M = 1'b0;
        #1;
        checkOutput("async_reset_ctrl", 32'({DMEM_Req, DMEM_WE, DMEM_BE, Bus_Err_M, Stall_M}), 32'h0);
        checkOutput("async_reset_addr", DMEM_Addr, 32'h0);
        checkOutput("async_reset_read", Read_Data_M, 32'h0);
        lastRead = 32'h0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        DMEM_RValid = 1'b1;
        @(posedge CLK); #1;
        DMEM_RValid = 1'b0;
        checkOutput("late_rvalid_ignored", Read_Data_M, 32'h0);
        checkOutput("late_rvalid_no_req", 32'(DMEM_Req), 32'h0);
        @(posedge CLK); #1;

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            op   = $urandom_range(0, 2);
            ctrl = (op == 0) ? ctrlTab[$urandom_range(0, 4)] : ctrlTab[$urandom_range(0, 2)];
            size = sizeOf(ctrl);
            addr = $urandom();
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(size) - 32'h1);
            hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            applyStimulus((op != 1), (op != 0), ctrl, addr, $urandom(), $urandom(),
                          $urandom_range(0, 3), $urandom_range(0, 3), hold);
        end

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("bus_queue_drained", 32'(busQ.size()), 32'h0);
        checkOutput("result_queue_drained", 32'(resQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #200000;
        reportUnexpected("watchdog_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
